fifo_ctrl: RTL and testbench

// - Pointer/flag controller that turns the register file into a FIFO.
// - Sits directly upstream of the 4x8 register file: drives its wr_en, w_addr and r_addr.
// - Register-file r_data is the FIFO read data (first-word-fall-through).
// - Producer issues wr pulses; consumer issues rd pulses; controller tracks occupancy and full/empty.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 118 +++++++++++
 tb/tb_fifo_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and pointer type for the FIFO controller and its 4x8 register file.
package fifo_pkg;
    localparam int FIFO_ADDR_WIDTH = 2;
    localparam int FIFO_DATA_WIDTH = 8;
    typedef logic [FIFO_ADDR_WIDTH-1:0] fifo_ptr_t;
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable; exposes the pointer and its successor.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic [ADDR_WIDTH-1:0] ptr_inc
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Wrap relies on natural binary overflow of the pointer width.
    assign ptr_inc = ptr_q + 1'b1;
    assign ptr     = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (reset) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_inc;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning the register file into a first-word-fall-through FIFO.
// Optional occupancy counter and flag consistency check enabled by FIFO_CTRL_COUNT_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  wr_err,
    output logic                  rd_err
`ifdef FIFO_CTRL_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] w_ptr, w_ptr_inc;
    logic [ADDR_WIDTH-1:0] r_ptr, r_ptr_inc;

    // A write while full is accepted only when a pop frees the head in the same cycle.
    assign wr_acc = ~reset & wr & (~full_q | rd);
    assign rd_acc = ~reset & rd & ~empty_q;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_ptr (
        .clk     (clk),
        .reset   (reset),
        .inc     (wr_acc),
        .ptr     (w_ptr),
        .ptr_inc (w_ptr_inc)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_ptr (
        .clk     (clk),
        .reset   (reset),
        .inc     (rd_acc),
        .ptr     (r_ptr),
        .ptr_inc (r_ptr_inc)
    );

    always_comb begin
        full_d   = full_q;
        empty_d  = empty_q;
        wr_err_d = 1'b0;
        rd_err_d = 1'b0;
        if (reset) begin
            full_d  = 1'b0;
            empty_d = 1'b1;
        end else begin
            wr_err_d = wr & ~wr_acc;
            rd_err_d = rd & ~rd_acc;
            unique case ({wr_acc, rd_acc})
                2'b10: begin
                    empty_d = 1'b0;
                    full_d  = (w_ptr_inc == r_ptr);
                end
                2'b01: begin
                    full_d  = 1'b0;
                    empty_d = (r_ptr_inc == w_ptr);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        full_q   <= full_d;
        empty_q  <= empty_d;
        wr_err_q <= wr_err_d;
        rd_err_q <= rd_err_d;
    end

    assign full   = full_q;
    assign empty  = empty_q;
    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;
    assign wr_en  = wr_acc;
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

`ifdef FIFO_CTRL_COUNT_EN
    logic [ADDR_WIDTH:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

    a_flags_match_count: assert property (@(posedge clk) disable iff (reset)
        (full_q == (count_q == {1'b1, {ADDR_WIDTH{1'b0}}})) && (empty_q == (count_q == '0)));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl paired with a behavioural 4x8 register file; queue-based reference model.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

    logic                       clk;
    logic                       reset;
    logic                       wr;
    logic                       rd;
    logic                       full;
    logic                       empty;
    logic                       wr_en;
    logic [FIFO_ADDR_WIDTH-1:0] w_addr;
    logic [FIFO_ADDR_WIDTH-1:0] r_addr;
    logic                       wr_err;
    logic                       rd_err;
`ifdef FIFO_CTRL_COUNT_EN
    logic [FIFO_ADDR_WIDTH:0]   count;
`endif
    logic [FIFO_DATA_WIDTH-1:0] w_data;
    logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_DATA_WIDTH-1:0] r_data;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: FIFO contents as a queue, pointers as write/read totals modulo depth.
    logic [FIFO_DATA_WIDTH-1:0] model_q [$];
    int  m_wp;
    int  m_rp;
    bit  m_wr_err;
    bit  m_rd_err;

    fifo_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .full   (full),
        .empty  (empty),
        .wr_en  (wr_en),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .wr_err (wr_err),
        .rd_err (rd_err)
`ifdef FIFO_CTRL_COUNT_EN
        ,
        .count  (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= w_data;
    end
    assign r_data = mem[r_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".full"},   32'(full),   32'(model_q.size() == DEPTH));
        check({tag, ".empty"},  32'(empty),  32'(model_q.size() == 0));
        check({tag, ".w_addr"}, 32'(w_addr), 32'(m_wp));
        check({tag, ".r_addr"}, 32'(r_addr), 32'(m_rp));
        check({tag, ".wr_err"}, 32'(wr_err), 32'(m_wr_err));
        check({tag, ".rd_err"}, 32'(rd_err), 32'(m_rd_err));
        if (model_q.size() != 0) check({tag, ".r_data"}, 32'(r_data), 32'(model_q[0]));
`ifdef FIFO_CTRL_COUNT_EN
        check({tag, ".count"},  32'(count),  32'(model_q.size()));
`endif
    endtask

    // One clock of traffic: drive after the falling edge, check wr_en before the rising edge,
    // update the model at the edge, check registered outputs at the next falling edge.
    task automatic step(input string tag, input bit w, input bit r, input logic [7:0] d);
        bit acc_w, acc_r;
        wr = w;
        rd = r;
        w_data = d;
        acc_w = w && (model_q.size() < DEPTH || r);
        acc_r = r && (model_q.size() > 0);
        #1;
        check({tag, ".wr_en"}, 32'(wr_en), 32'(acc_w));
        @(posedge clk);
        if (acc_r) void'(model_q.pop_front());
        if (acc_w) model_q.push_back(d);
        m_wp = (m_wp + int'(acc_w)) % DEPTH;
        m_rp = (m_rp + int'(acc_r)) % DEPTH;
        m_wr_err = w && !acc_w;
        m_rd_err = r && !acc_r;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        wr = 1'b1;
        rd = 1'b0;
        #1;
        check({tag, ".wr_en_in_reset"}, 32'(wr_en), 32'd0);
        @(posedge clk);
        model_q.delete();
        m_wp = 0;
        m_rp = 0;
        m_wr_err = 1'b0;
        m_rd_err = 1'b0;
        @(negedge clk);
        check_state(tag);
        reset = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        w_data = '0;
        m_wp = 0;
        m_rp = 0;
        @(negedge clk);
        @(negedge clk);
        do_reset("rst0");

        step("fill0", 1, 0, 8'h11);
        step("fill1", 1, 0, 8'h22);
        step("fill2", 1, 0, 8'h33);
        step("fill3", 1, 0, 8'h44);
        check("full_after_4", 32'(full), 32'd1);
        step("ovf", 1, 0, 8'h55);
        step("ovf_again", 1, 0, 8'h56);
        step("ovf_clear", 0, 0, 8'h00);
        step("full_wr_rd", 1, 1, 8'h77);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 8'h00);
        check("empty_after_drain", 32'(empty), 32'd1);
        step("udf", 0, 1, 8'h00);
        step("empty_wr_rd", 1, 1, 8'h66);
        step("pop66", 0, 1, 8'h00);
        for (int i = 0; i < 6; i++) step("mixed", 1'(i % 3 != 2), 1'(i % 2), 8'(8'h80 + i));

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            step("rand", sel < 6, sel >= 4, 8'($urandom));
            if (sel == 9 && i % 7 == 0) do_reset("rand_rst");
        end

        while (model_q.size() < 3) step("prefill", 1, 0, 8'($urandom));
        while (model_q.size() > 3) step("predrain", 0, 1, 8'h00);
        do_reset("rst3");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
